// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard/flush controller: load-use bubbles, MUL/DIV wait with timeout,
// redirect squash and multi-cycle trap drain for the 5-stage core.
module hazard_flush_ctrl #(
  parameter int unsigned MD_TIMEOUT   = 64,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_load,
  input  logic       ex_redirect,
  input  logic       md_start,
  input  logic       md_done,
  input  logic       trap_req,
  output logic       stall_pc,
  output logic       stall_if_id,
  output logic       stall_id_ex,
  output logic       flush_if_id,
  output logic       flush_id_ex,
  output logic       flush_ex_mem,
  output logic       md_kill,
  output logic       md_timeout,
  output logic       trap_ack
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MD_WAIT    = 2'd1,
    TRAP_DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MD_LIMIT  = CNT_W'(MD_TIMEOUT);
  localparam logic [CNT_W-1:0] DRN_LIMIT = CNT_W'(DRAIN_CYCLES);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load_use;

  // x0 is hardwired zero, so a load to x0 never creates a dependency
  assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    md_kill      = 1'b0;
    md_timeout   = 1'b0;
    trap_ack     = 1'b0;

    case (state)
      RUN: begin
        if (trap_req) begin
          stall_pc     = 1'b1;
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
          state_nxt    = TRAP_DRAIN;
          cnt_nxt      = CNT_ONE;
        end else if (ex_redirect) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (md_start && !md_done) begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          stall_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
          state_nxt    = MD_WAIT;
          cnt_nxt      = CNT_ONE;
        end else if (md_start) begin
          // single-cycle result: nothing to hold
        end else if (load_use) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end
      end

      MD_WAIT: begin
        if (trap_req) begin
          md_kill      = 1'b1;
          stall_pc     = 1'b1;
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
          state_nxt    = TRAP_DRAIN;
          cnt_nxt      = CNT_ONE;
        end else if (md_done) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (cnt == MD_LIMIT) begin
          // abort the unit; the stuck op in EX is replaced by a bubble
          md_timeout   = 1'b1;
          md_kill      = 1'b1;
          flush_ex_mem = 1'b1;
          flush_id_ex  = 1'b1;
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          state_nxt    = RUN;
          cnt_nxt      = '0;
        end else begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          stall_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
          cnt_nxt      = cnt + CNT_ONE;
        end
      end

      TRAP_DRAIN: begin
        stall_pc     = 1'b1;
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        flush_ex_mem = 1'b1;
        if (cnt == DRN_LIMIT) begin
          trap_ack  = 1'b1;
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase

    // reset wins over everything in flight and empties every stage
    if (reset) begin
      stall_pc     = 1'b0;
      stall_if_id  = 1'b0;
      stall_id_ex  = 1'b0;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
      md_kill      = 1'b0;
      md_timeout   = 1'b0;
      trap_ack     = 1'b0;
    end
  end

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed bench for hazard_flush_ctrl; outputs packed as
// {stall_pc,stall_if_id,stall_id_ex,flush_if_id,flush_id_ex,flush_ex_mem,md_kill,md_timeout,trap_ack}.
module tb_hazard_flush_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_is_load, ex_redirect;
  logic       md_start, md_done, trap_req;
  logic       stall_pc, stall_if_id, stall_id_ex;
  logic       flush_if_id, flush_id_ex, flush_ex_mem;
  logic       md_kill, md_timeout, trap_ack;

  int checks = 0;
  int errors = 0;

  localparam logic [8:0] NONE = 9'b000_000_000;
  localparam logic [8:0] LU   = 9'b110_010_000;
  localparam logic [8:0] RED  = 9'b000_110_000;
  localparam logic [8:0] MDS  = 9'b111_001_000;
  localparam logic [8:0] TRAP = 9'b100_111_000;
  localparam logic [8:0] TRPK = 9'b100_111_100;
  localparam logic [8:0] TOUT = 9'b110_011_110;
  localparam logic [8:0] ACK  = 9'b100_111_001;
  localparam logic [8:0] RST  = 9'b000_111_000;

  hazard_flush_ctrl #(.MD_TIMEOUT(64), .DRAIN_CYCLES(3), .CNT_W(7)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rd        (ex_rd),
    .ex_is_load   (ex_is_load),
    .ex_redirect  (ex_redirect),
    .md_start     (md_start),
    .md_done      (md_done),
    .trap_req     (trap_req),
    .stall_pc     (stall_pc),
    .stall_if_id  (stall_if_id),
    .stall_id_ex  (stall_id_ex),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .flush_ex_mem (flush_ex_mem),
    .md_kill      (md_kill),
    .md_timeout   (md_timeout),
    .trap_ack     (trap_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // inputs are set just after a rising edge; sample mid-cycle, then advance one cycle
  task automatic cyc(input string tag, input logic [8:0] exp);
    @(negedge clk);
    check(tag, {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex,
                flush_ex_mem, md_kill, md_timeout, trap_ack}, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_is_load = 1'b0;
    ex_redirect = 1'b0; md_start = 1'b0; md_done = 1'b0; trap_req = 1'b0;
  endtask

  task automatic set_lu();
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    cyc("reset0", RST);
    cyc("reset1", RST);
    reset = 1'b0;
    cyc("idle", NONE);

    // load-use detection and its qualifiers
    set_lu();                          cyc("lu_rs1", LU);
    ex_rd = 5'd0; id_rs1 = 5'd0;       cyc("lu_x0", NONE);
    set_lu(); id_use_rs1 = 1'b0;       cyc("lu_nouse", NONE);
    id_use_rs2 = 1'b1; id_rs2 = 5'd5;  cyc("lu_rs2", LU);
    id_rs2 = 5'd6;                     cyc("lu_diff", NONE);
    idle(); set_lu(); ex_is_load = 1'b0; cyc("lu_noload", NONE);

    // redirect beats load-use
    idle(); set_lu(); ex_redirect = 1'b1; cyc("redir_lu", RED);

    // single-cycle MUL: no stall
    idle(); md_start = 1'b1; md_done = 1'b1; cyc("md_1cyc", NONE);
    idle(); set_lu();                         cyc("md_1cyc_run", LU);

    // MUL/DIV finishing after 4 cycles; md_start beats load-use
    idle(); set_lu(); md_start = 1'b1; cyc("md_T0", MDS);
    idle(); set_lu(); ex_redirect = 1'b1; cyc("md_T1_ign", MDS);
    idle();                             cyc("md_T2", MDS);
    cyc("md_T3", MDS);
    md_done = 1'b1;                     cyc("md_T4_done", NONE);
    idle(); set_lu();                   cyc("md_T5_run", LU);

    // MUL/DIV that never finishes: timeout at T+64
    idle(); md_start = 1'b1; cyc("to_T0", MDS);
    md_start = 1'b0;
    for (int i = 1; i < 64; i++) cyc("to_wait", MDS);
    cyc("to_T64", TOUT);
    set_lu(); cyc("to_run", LU);

    // trap during MD_WAIT at T+2
    idle(); md_start = 1'b1; cyc("tm_T0", MDS);
    md_start = 1'b0;         cyc("tm_T1", MDS);
    trap_req = 1'b1;         cyc("tm_T2", TRPK);
    trap_req = 1'b0;         cyc("tm_T3", TRAP);
    cyc("tm_T4", TRAP);
    cyc("tm_T5", ACK);
    set_lu();                cyc("tm_run", LU);

    // trap in RUN beats redirect; trap_req held during drain is ignored
    idle(); trap_req = 1'b1; ex_redirect = 1'b1; cyc("tr_T0", TRAP);
    ex_redirect = 1'b0; cyc("tr_T1", TRAP);
    cyc("tr_T2", TRAP);
    cyc("tr_T3", ACK);
    trap_req = 1'b0;    cyc("tr_T4", NONE);

    // reset in the middle of a drain
    trap_req = 1'b1; cyc("rd_T0", TRAP);
    trap_req = 1'b0; cyc("rd_T1", TRAP);
    reset = 1'b1;    cyc("rd_T2_rst", RST);
    cyc("rd_T3_rst", RST);
    reset = 1'b0;    cyc("rd_idle", NONE);
    // counter restarted: a fresh drain acks after exactly 3 cycles
    trap_req = 1'b1; cyc("rd2_T0", TRAP);
    trap_req = 1'b0; cyc("rd2_T1", TRAP);
    cyc("rd2_T2", TRAP);
    cyc("rd2_T3", ACK);
    cyc("rd2_T4", NONE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
